// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the main-RAM port arbiter.
//   ram_arb_state_t : arbiter FSM state encoding
//   RAM_AW / RAM_DW : RAM byte-address and data widths
//   sat_inc4        : 4-bit saturating increment used by the starvation guard
package ram_arb_pkg;

  localparam int RAM_AW = 21;
  localparam int RAM_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2,
    GAP     = 2'd3
  } ram_arb_state_t;

  // Increment val by one, clamping at lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    if (val >= lim) begin
      return lim;
    end else begin
      return val + 4'd1;
    end
  endfunction

endpackage

// File: rtl/ram_arb.sv
// ram_arb: arbiter/sequencer sharing the 2 MB main-RAM port between the V810
// CPU (decoded RAM chip-enable) and a DMA master. CPU has fixed priority; a
// starvation guard forces DMA in after STARVE_LIMIT consecutive CPU grants
// taken while DMA_REQ was pending. Every access is followed by GAP_CYCLES
// CE cycles with RAM_CEn high.
//
// Ports:
//   CLK, RESn (async, active-low), CE (clock enable for all state)
//   CPU_*  : CPU side; address/data/strobes pass straight through to the RAM
//            during a CPU access, CPU_READYn mirrors RAM_READYn
//   DMA_*  : DMA side; request is latched at grant, DMA_ACK pulses for one
//            CE cycle with DMA_DO valid
//   RAM_*  : core RAM interface
//   PERF_CPU_WAIT : CPU stall-cycle counter
//
// Optional feature macro: RAM_ARB_PERF_EN. When defined, PERF_CPU_WAIT counts
// CE cycles in which the CPU requests the RAM but is held off (saturating,
// cleared only by reset). When undefined the output is tied to zero.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic              CLK,
  input  logic              RESn,
  input  logic              CE,
  input  logic              CPU_CEn,
  input  logic [RAM_AW-1:0] CPU_A,
  input  logic [RAM_DW-1:0] CPU_DI,
  input  logic              CPU_WEn,
  input  logic [3:0]        CPU_BEn,
  output logic [RAM_DW-1:0] CPU_DO,
  output logic              CPU_READYn,
  input  logic              DMA_REQ,
  input  logic [RAM_AW-1:0] DMA_A,
  input  logic [RAM_DW-1:0] DMA_DI,
  input  logic              DMA_WE,
  input  logic [3:0]        DMA_BE,
  output logic              DMA_ACK,
  output logic [RAM_DW-1:0] DMA_DO,
  output logic [RAM_AW-1:0] RAM_A,
  output logic [RAM_DW-1:0] RAM_DI,
  output logic              RAM_CEn,
  output logic              RAM_WEn,
  output logic [3:0]        RAM_BEn,
  input  logic              RAM_READYn,
  input  logic [RAM_DW-1:0] RAM_DO,
  output logic [15:0]       PERF_CPU_WAIT
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // GAP counts down to zero, so it is loaded with one less than its length.
  localparam logic [1:0] GAP_INIT   = 2'(GAP_CYCLES - 1);

  ram_arb_state_t    state_q;
  logic [3:0]        starve_q;
  logic [1:0]        gap_q;
  logic [RAM_AW-1:0] dma_a_q;
  logic [RAM_DW-1:0] dma_di_q;
  logic              dma_we_q;
  logic [3:0]        dma_be_q;
  logic              dma_ack_q;
  logic [RAM_DW-1:0] dma_do_q;
  logic [RAM_DW-1:0] cpu_do_q;
  logic              cpu_grant_s;

  // CPU wins in IDLE unless DMA is waiting and the starvation count is exhausted.
  assign cpu_grant_s = !CPU_CEn && (!DMA_REQ || (starve_q < STARVE_MAX));

  // Arbiter FSM with DMA request latch, starvation counter and completion registers.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      gap_q     <= 2'd0;
      dma_a_q   <= '0;
      dma_di_q  <= '0;
      dma_we_q  <= 1'b0;
      dma_be_q  <= 4'h0;
      dma_ack_q <= 1'b0;
      dma_do_q  <= '0;
      cpu_do_q  <= '0;
    end else if (CE) begin
      // ACK is a single-CE-cycle pulse; it is only re-armed by a DMA completion.
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_grant_s) begin
            state_q  <= CPU_ACC;
            // Only grants taken while DMA waits count towards starvation.
            starve_q <= DMA_REQ ? sat_inc4(starve_q, STARVE_MAX) : 4'd0;
          end else if (DMA_REQ) begin
            state_q  <= DMA_ACC;
            dma_a_q  <= DMA_A;
            dma_di_q <= DMA_DI;
            dma_we_q <= DMA_WE;
            dma_be_q <= DMA_BE;
          end else begin
            state_q <= IDLE;
          end
        end
        CPU_ACC: begin
          // Tracked every CE cycle so CPU_DO keeps the final value after the access.
          cpu_do_q <= RAM_DO;
          // Completion or a CPU that drops its select both close the access.
          if (!RAM_READYn || CPU_CEn) begin
            state_q <= GAP;
            gap_q   <= GAP_INIT;
          end else begin
            state_q <= CPU_ACC;
          end
        end
        DMA_ACC: begin
          if (!RAM_READYn) begin
            dma_do_q  <= RAM_DO;
            dma_ack_q <= 1'b1;
            starve_q  <= 4'd0;
            state_q   <= GAP;
            gap_q     <= GAP_INIT;
          end else begin
            state_q <= DMA_ACC;
          end
        end
        GAP: begin
          if (gap_q == 2'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // RAM-side and CPU-side output steering; CPU accesses pass through with no added latency.
  always_comb begin
    RAM_CEn    = 1'b1;
    RAM_WEn    = 1'b1;
    RAM_BEn    = 4'hF;
    RAM_A      = '0;
    RAM_DI     = '0;
    CPU_READYn = 1'b1;
    CPU_DO     = cpu_do_q;
    case (state_q)
      CPU_ACC: begin
        RAM_CEn    = 1'b0;
        RAM_WEn    = CPU_WEn;
        RAM_BEn    = CPU_BEn;
        RAM_A      = CPU_A;
        RAM_DI     = CPU_DI;
        CPU_READYn = RAM_READYn;
        CPU_DO     = RAM_DO;
      end
      DMA_ACC: begin
        RAM_CEn = 1'b0;
        RAM_WEn = ~dma_we_q;
        RAM_BEn = ~dma_be_q;
        RAM_A   = dma_a_q;
        RAM_DI  = dma_di_q;
      end
      IDLE, GAP: begin
        RAM_CEn = 1'b1;
      end
      default: begin
        RAM_CEn = 1'b1;
      end
    endcase
  end

  assign DMA_ACK = dma_ack_q;
  assign DMA_DO  = dma_do_q;

`ifdef RAM_ARB_PERF_EN
  logic [15:0] perf_q;
  logic [15:0] perf_d;
  logic        cpu_stall_s;

  // A stall is a requesting CPU that is not in, and not about to enter, CPU_ACC.
  always_comb begin
    cpu_stall_s = !CPU_CEn && (state_q != CPU_ACC) && !((state_q == IDLE) && cpu_grant_s);
    if (cpu_stall_s && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      perf_q <= 16'h0000;
    end else if (CE) begin
      perf_q <= perf_d;
    end
  end

  assign PERF_CPU_WAIT = perf_q;
`else
  assign PERF_CPU_WAIT = 16'h0000;
`endif

endmodule
